// File: rtl/countgen_poller_if.sv
// Wishbone link between the countgen poller (master) and the countgen slave.
// 4-bit address and 32-bit data. Signal names are written from the master's side.
//   cyc_o, stb_o, we_o  cycle, strobe and write enable (master -> slave)
//   adr_o, dat_o        address and write data (master -> slave)
//   dat_i, ack_i        read data and acknowledge (slave -> master)
interface countgen_poller_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [3:0]  adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o,
      output dat_i, ack_i
   );
endinterface

// File: rtl/countgen_poller.sv
// Wishbone master that drives the countgen slave. It issues single config
// writes on request and, on a start pulse, reads counters 1..NUM_CH and hands
// each value to downstream logic as a valid/ready sample stream.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   wb                 Wishbone master side (cyc/stb/we/adr/dat out, dat/ack in)
//   start_i            pulse: begin a counter sweep
//   cfg_wr_i           pulse: one config write of cfg_dat_i to cfg_adr_i
//   busy_o             high whenever the FSM is not idle
//   smp_valid_o/_ready_i, smp_idx_o, smp_dat_o   sample stream
//   err_o              sticky bus-timeout flag, cleared by the next accepted command
//
// state | meaning
// IDLE  | no transfer; accepts cfg_wr_i (priority) or start_i / pending start
// WR    | config write strobe out, waiting for ack_i
// RD    | counter read strobe out, waiting for ack_i
// CAP   | registered read data arrives; capture it into the sample
// PUSH  | sample offered downstream, waiting for smp_ready_i
module countgen_poller #(
   parameter int NUM_CH  = 8,
   parameter int RD_DLY  = 1,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   countgen_poller_if.master wb,
   input  logic              start_i,
   input  logic              cfg_wr_i,
   input  logic [3:0]        cfg_adr_i,
   input  logic [31:0]       cfg_dat_i,
   output logic              busy_o,
   output logic              smp_valid_o,
   input  logic              smp_ready_i,
   output logic [3:0]        smp_idx_o,
   output logic [31:0]       smp_dat_o,
   output logic              err_o
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);
   localparam logic [3:0] TMO_LOAD = 4'(TIMEOUT);

   typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_CAP, ST_PUSH} state_t;

   state_t     state;
   logic [3:0] idx;
   logic [3:0] tmo_cnt;
   logic       start_pend;
   logic       tmo_last;

   // Down-counter loaded with TIMEOUT at launch; the strobe is abandoned after
   // TIMEOUT unacknowledged cycles. An ack on the final cycle still wins.
   assign tmo_last = (tmo_cnt == 4'd1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         idx         <= '0;
         tmo_cnt     <= '0;
         start_pend  <= 1'b0;
         wb.cyc_o    <= 1'b0;
         wb.stb_o    <= 1'b0;
         wb.we_o     <= 1'b0;
         wb.adr_o    <= '0;
         wb.dat_o    <= '0;
         busy_o      <= 1'b0;
         smp_valid_o <= 1'b0;
         smp_idx_o   <= '0;
         smp_dat_o   <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A start that collided with a write is served before any new write.
               if (cfg_wr_i && !start_pend) begin
                  wb.adr_o   <= cfg_adr_i;
                  wb.dat_o   <= cfg_dat_i;
                  wb.cyc_o   <= 1'b1;
                  wb.stb_o   <= 1'b1;
                  wb.we_o    <= 1'b1;
                  tmo_cnt    <= TMO_LOAD;
                  err_o      <= 1'b0;
                  busy_o     <= 1'b1;
                  start_pend <= start_i;
                  state      <= ST_WR;
               end else if (start_i || start_pend) begin
                  idx        <= '0;
                  wb.adr_o   <= 4'd1;
                  wb.cyc_o   <= 1'b1;
                  wb.stb_o   <= 1'b1;
                  wb.we_o    <= 1'b0;
                  tmo_cnt    <= TMO_LOAD;
                  err_o      <= 1'b0;
                  busy_o     <= 1'b1;
                  start_pend <= 1'b0;
                  state      <= ST_RD;
               end
            end

            ST_WR: begin
               if (wb.ack_i) begin
                  wb.cyc_o <= 1'b0;
                  wb.stb_o <= 1'b0;
                  wb.we_o  <= 1'b0;
                  busy_o   <= 1'b0;
                  state    <= ST_IDLE;
               end else if (tmo_last) begin
                  // Drop a pending start too, so the error stays visible to the host.
                  wb.cyc_o   <= 1'b0;
                  wb.stb_o   <= 1'b0;
                  wb.we_o    <= 1'b0;
                  err_o      <= 1'b1;
                  start_pend <= 1'b0;
                  busy_o     <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 4'd1;
               end
            end

            ST_RD: begin
               if (wb.ack_i) begin
                  wb.cyc_o <= 1'b0;
                  wb.stb_o <= 1'b0;
                  if (RD_DLY == 0) begin
                     smp_dat_o   <= wb.dat_i;
                     smp_idx_o   <= idx;
                     smp_valid_o <= 1'b1;
                     state       <= ST_PUSH;
                  end else begin
                     state <= ST_CAP;
                  end
               end else if (tmo_last) begin
                  wb.cyc_o <= 1'b0;
                  wb.stb_o <= 1'b0;
                  err_o    <= 1'b1;
                  busy_o   <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 4'd1;
               end
            end

            ST_CAP: begin
               smp_dat_o   <= wb.dat_i;
               smp_idx_o   <= idx;
               smp_valid_o <= 1'b1;
               state       <= ST_PUSH;
            end

            ST_PUSH: begin
               if (smp_ready_i) begin
                  smp_valid_o <= 1'b0;
                  if (idx == LAST_IDX) begin
                     busy_o <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     idx      <= idx + 4'd1;
                     wb.adr_o <= idx + 4'd2;
                     wb.cyc_o <= 1'b1;
                     wb.stb_o <= 1'b1;
                     tmo_cnt  <= TMO_LOAD;
                     state    <= ST_RD;
                  end
               end
            end

            default: begin
               wb.cyc_o    <= 1'b0;
               wb.stb_o    <= 1'b0;
               wb.we_o     <= 1'b0;
               smp_valid_o <= 1'b0;
               busy_o      <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countgen_poller.sv
// Bench for countgen_poller: a countgen slave model with registered read data
// and programmable ack latency, a sample/bus monitor, and directed plus
// randomized scenarios compared against the expected sweep result.
module tb_countgen_poller;

   localparam int NUM_CH  = 8;
   localparam int TIMEOUT = 15;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        cfg_wr_i;
   logic [3:0]  cfg_adr_i;
   logic [31:0] cfg_dat_i;
   logic        busy_o;
   logic        smp_valid_o;
   logic        smp_ready_i = 1'b1;
   logic [3:0]  smp_idx_o;
   logic [31:0] smp_dat_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   countgen_poller_if wb();

   countgen_poller #(.NUM_CH(NUM_CH), .RD_DLY(1), .TIMEOUT(TIMEOUT)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wb          (wb.master),
      .start_i     (start_i),
      .cfg_wr_i    (cfg_wr_i),
      .cfg_adr_i   (cfg_adr_i),
      .cfg_dat_i   (cfg_dat_i),
      .busy_o      (busy_o),
      .smp_valid_o (smp_valid_o),
      .smp_ready_i (smp_ready_i),
      .smp_idx_o   (smp_idx_o),
      .smp_dat_o   (smp_dat_o),
      .err_o       (err_o)
   );

   // ---------------- slave model ----------------
   logic [31:0] cnt_mem [0:15];
   logic [31:0] rd_q     = '0;
   int          wcnt     = 0;
   int          wait_req = 0;
   bit          rand_waits = 1'b0;
   bit          noack_en   = 1'b0;
   logic [3:0]  noack_adr  = '0;

   assign wb.ack_i = wb.cyc_o && wb.stb_o && (wcnt >= wait_req) &&
                     !(noack_en && (wb.adr_o == noack_adr));
   assign wb.dat_i = rd_q;

   always @(posedge clk_i) begin
      if (wb.cyc_o && wb.stb_o && wb.ack_i) begin
         wcnt     <= 0;
         wait_req <= rand_waits ? int'($urandom_range(0, 3)) : 0;
         if (!wb.we_o) rd_q <= cnt_mem[wb.adr_o];
      end else if (wb.cyc_o && wb.stb_o) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
      end
   end

   // ---------------- sample ready driver ----------------
   int rdy_mode = 0;
   int hold_cnt = 0;

   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0: begin
            smp_ready_i = 1'b1;
            hold_cnt    = 0;
         end
         1: smp_ready_i = 1'($urandom_range(0, 1));
         default: begin
            if (smp_valid_o && smp_idx_o == 4'd3 && hold_cnt < 5) begin
               smp_ready_i = 1'b0;
               hold_cnt    = hold_cnt + 1;
            end else begin
               smp_ready_i = 1'b1;
            end
         end
      endcase
   end

   // ---------------- monitor ----------------
   logic [35:0] smp_q  [$];
   logic [4:0]  xfer_q [$];
   logic [31:0] xdat_q [$];
   int          stb_run = 0, last_run = 0;
   int          bus_viol = 0, stab_viol = 0, stb_in_push = 0, wr_cycles = 0;
   logic        prev_ack = 1'b0, prev_cyc = 1'b0, prev_hold = 1'b0, p_we = 1'b0;
   logic [3:0]  p_adr = '0, p_idx = '0;
   logic [31:0] p_dato = '0, p_dat = '0;

   always @(negedge clk_i) begin
      if (wb.stb_o && !wb.cyc_o) bus_viol <= bus_viol + 1;
      if (prev_ack && wb.cyc_o) bus_viol <= bus_viol + 1;
      if (prev_cyc && wb.cyc_o &&
          (wb.adr_o != p_adr || wb.we_o != p_we || wb.dat_o != p_dato))
         bus_viol <= bus_viol + 1;
      if (prev_hold && (!smp_valid_o || smp_idx_o != p_idx || smp_dat_o != p_dat))
         stab_viol <= stab_viol + 1;
      if (smp_valid_o && wb.stb_o) stb_in_push <= stb_in_push + 1;
      if (smp_valid_o && smp_ready_i) smp_q.push_back({smp_idx_o, smp_dat_o});
      if (wb.cyc_o && wb.stb_o && wb.ack_i) begin
         xfer_q.push_back({wb.we_o, wb.adr_o});
         xdat_q.push_back(wb.dat_o);
      end
      if (wb.cyc_o && wb.stb_o && wb.we_o) wr_cycles <= wr_cycles + 1;
      if (wb.stb_o) stb_run <= stb_run + 1;
      else if (stb_run != 0) begin
         last_run <= stb_run;
         stb_run  <= 0;
      end
      prev_ack  <= wb.cyc_o && wb.stb_o && wb.ack_i;
      prev_cyc  <= wb.cyc_o;
      p_adr     <= wb.adr_o;
      p_we      <= wb.we_o;
      p_dato    <= wb.dat_o;
      prev_hold <= smp_valid_o && !smp_ready_i;
      p_idx     <= smp_idx_o;
      p_dat     <= smp_dat_o;
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_i); #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
   endtask

   task automatic pulse_cfg(input logic [3:0] adr, input logic [31:0] dat);
      @(posedge clk_i); #1;
      cfg_wr_i = 1'b1; cfg_adr_i = adr; cfg_dat_i = dat;
      @(posedge clk_i); #1 cfg_wr_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; i < limit && busy_o; i++) @(negedge clk_i);
      check_val({tag, "_idle"}, 36'(busy_o), 36'(0));
   endtask

   task automatic fill_counters(input bit ramp);
      for (int i = 0; i < 16; i++)
         cnt_mem[i] = ramp ? 32'(32'h10 + i - 1) : $urandom;
   endtask

   // Expected result of a sweep: channels 0..n_exp-1 deliver counter n+1, and
   // every acked read targets address n+1 in order.
   task automatic check_sweep(input string tag, input int n_exp);
      check_val({tag, "_nsmp"}, 36'(smp_q.size()), 36'(n_exp));
      for (int i = 0; i < smp_q.size() && i < n_exp; i++) begin
         check_val($sformatf("%s_idx%0d", tag, i), 36'(smp_q[i][35:32]), 36'(i));
         check_val($sformatf("%s_dat%0d", tag, i), 36'(smp_q[i][31:0]), 36'(cnt_mem[i + 1]));
      end
   endtask

   task automatic check_reads(input string tag, input int first, input int n_exp);
      check_val({tag, "_nxfer"}, 36'(xfer_q.size()), 36'(first + n_exp));
      for (int i = 0; i < n_exp && first + i < xfer_q.size(); i++)
         check_val($sformatf("%s_radr%0d", tag, i), 36'(xfer_q[first + i]), 36'(i + 1));
   endtask

   task automatic do_sweep(input string tag, input int n_exp);
      smp_q.delete(); xfer_q.delete(); xdat_q.delete();
      pulse_start();
      check_val({tag, "_busy"}, 36'(busy_o), 36'(1));
      check_val({tag, "_errclr"}, 36'(err_o), 36'(0));
      wait_idle(tag, 600);
      @(posedge clk_i); #1;
      check_sweep(tag, n_exp);
      check_reads(tag, 0, n_exp);
      check_val({tag, "_err"}, 36'(err_o), 36'(n_exp != NUM_CH));
   endtask

   task automatic do_write(input string tag, input logic [3:0] adr, input logic [31:0] dat);
      int n0;
      n0 = xfer_q.size();
      pulse_cfg(adr, dat);
      wait_idle(tag, 100);
      @(posedge clk_i); #1;
      check_val({tag, "_nxfer"}, 36'(xfer_q.size()), 36'(n0 + 1));
      if (xfer_q.size() > n0) begin
         check_val({tag, "_adr"}, 36'(xfer_q[n0]), 36'({1'b1, adr}));
         check_val({tag, "_dat"}, 36'(xdat_q[n0]), 36'(dat));
      end
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int          wr0;
      logic [31:0] cdat;
      rst_i = 1'b1; start_i = 1'b0; cfg_wr_i = 1'b0; cfg_adr_i = '0; cfg_dat_i = '0;
      fill_counters(1'b1);
      repeat (2) @(posedge clk_i);
      #1;
      check_val("rst_cyc",    36'(wb.cyc_o),    36'(0));
      check_val("rst_stb",    36'(wb.stb_o),    36'(0));
      check_val("rst_we",     36'(wb.we_o),     36'(0));
      check_val("rst_adr",    36'(wb.adr_o),    36'(0));
      check_val("rst_dato",   36'(wb.dat_o),    36'(0));
      check_val("rst_busy",   36'(busy_o),      36'(0));
      check_val("rst_valid",  36'(smp_valid_o), 36'(0));
      check_val("rst_idx",    36'(smp_idx_o),   36'(0));
      check_val("rst_smpdat", 36'(smp_dat_o),   36'(0));
      check_val("rst_err",    36'(err_o),       36'(0));
      @(negedge clk_i) rst_i = 1'b0;

      // Zero-wait config write: one bus cycle, busy drops on the next cycle.
      wr0 = wr_cycles;
      pulse_cfg(4'd0, 32'h0000_00A5);
      check_val("cw_busy1", 36'(busy_o),   36'(1));
      check_val("cw_cyc1",  36'(wb.cyc_o), 36'(1));
      check_val("cw_we1",   36'(wb.we_o),  36'(1));
      check_val("cw_adr1",  36'(wb.adr_o), 36'(0));
      check_val("cw_dat1",  36'(wb.dat_o), 36'(32'hA5));
      @(posedge clk_i); #1;
      check_val("cw_busy0", 36'(busy_o),   36'(0));
      check_val("cw_cyc0",  36'(wb.cyc_o), 36'(0));
      repeat (2) @(posedge clk_i);
      #1 check_val("cw_nwr", 36'(wr_cycles - wr0), 36'(1));

      // Random config writes with random ack latency.
      rand_waits = 1'b1;
      for (int k = 0; k < 4; k++)
         do_write($sformatf("rw%0d", k), 4'($urandom_range(0, NUM_CH)), $urandom);

      // Ramp sweep with zero-wait slave and ready tied high.
      rand_waits = 1'b0;
      do_sweep("sw_ramp", NUM_CH);

      // Randomized sweeps: random counters, ack latency and ready.
      rand_waits = 1'b1;
      rdy_mode   = 1;
      for (int k = 0; k < 3; k++) begin
         fill_counters(1'b0);
         do_sweep($sformatf("sw_rnd%0d", k), NUM_CH);
      end
      rdy_mode = 0;

      // Backpressure: ready held low for 5 cycles at idx 3.
      fill_counters(1'b0);
      rand_waits = 1'b0;
      @(posedge clk_i); #1 rdy_mode = 2;
      do_sweep("bp", NUM_CH);
      check_val("bp_hold", 36'(hold_cnt), 36'(5));
      rdy_mode = 0;

      // Timeout at address 2: only sample 0 delivered, strobe held TIMEOUT cycles.
      noack_en = 1'b1; noack_adr = 4'd2;
      do_sweep("to", 1);
      check_val("to_stbrun", 36'(last_run), 36'(TIMEOUT));
      noack_en = 1'b0;
      do_sweep("to_recover", NUM_CH);

      // Collision: write first, then full sweep; mid-sweep commands ignored.
      fill_counters(1'b0);
      rand_waits = 1'b1;
      smp_q.delete(); xfer_q.delete(); xdat_q.delete();
      cdat = $urandom;
      @(posedge clk_i); #1;
      start_i = 1'b1; cfg_wr_i = 1'b1; cfg_adr_i = 4'd3; cfg_dat_i = cdat;
      @(posedge clk_i); #1;
      start_i = 1'b0; cfg_wr_i = 1'b0;
      for (int i = 0; i < 300 && smp_q.size() < 3; i++) @(negedge clk_i);
      check_val("col_mid_busy", 36'(busy_o), 36'(1));
      @(posedge clk_i); #1;
      start_i = 1'b1; cfg_wr_i = 1'b1; cfg_adr_i = 4'd5;
      @(posedge clk_i); #1;
      start_i = 1'b0; cfg_wr_i = 1'b0;
      wait_idle("col", 600);
      repeat (20) @(posedge clk_i);
      #1;
      check_val("col_busy_after", 36'(busy_o), 36'(0));
      check_sweep("col", NUM_CH);
      if (xfer_q.size() > 0) begin
         check_val("col_wadr", 36'(xfer_q[0]), 36'({1'b1, 4'd3}));
         check_val("col_wdat", 36'(xdat_q[0]), 36'(cdat));
      end
      check_reads("col", 1, NUM_CH);

      // Async reset while reading channel 4.
      rand_waits = 1'b0;
      noack_en = 1'b1; noack_adr = 4'd5;
      smp_q.delete(); xfer_q.delete(); xdat_q.delete();
      pulse_start();
      for (int i = 0; i < 300 && !(wb.stb_o && wb.adr_o == 4'd5); i++) @(negedge clk_i);
      check_val("ar_reach", 36'(wb.stb_o), 36'(1));
      #2 rst_i = 1'b1;
      #1;
      check_val("ar_cyc",   36'(wb.cyc_o),    36'(0));
      check_val("ar_stb",   36'(wb.stb_o),    36'(0));
      check_val("ar_valid", 36'(smp_valid_o), 36'(0));
      @(posedge clk_i); #1 rst_i = 1'b0;
      noack_en = 1'b0;
      @(posedge clk_i); #1;
      check_val("ar_busy", 36'(busy_o), 36'(0));
      check_val("ar_err",  36'(err_o),  36'(0));
      check_sweep("ar", 4);
      do_sweep("ar_after", NUM_CH);

      check_val("bus_rules",     36'(bus_viol),    36'(0));
      check_val("smp_stable",    36'(stab_viol),   36'(0));
      check_val("no_stb_in_push", 36'(stb_in_push), 36'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
